sample_sequencer: RTL and testbench

- Parametrised successor to the fixed three-state load/save controller.
- Sequences NUM_CH sensor channels round-robin with a per-sample request/ready handshake and a configurable load-settle delay.
- Writes each captured sample to SPRAM at an internally managed address, in circular or stop-when-full mode.
- Sits between the sensor front-end and the SPRAM write port.

---
 rtl/sample_seq_pkg.sv | 11 +
 rtl/spram_addr_ctr.sv | 60 ++++++
 rtl/sample_sequencer.sv | 142 ++++++++++++++
 tb/tb_sample_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_seq_pkg.sv
// Shared types and helpers for the sample sequencer and its address counter.
package sample_seq_pkg;

  typedef enum logic [1:0] {IDLE, REQUEST, LOAD, SAVE} seq_state_t;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spram_addr_ctr.sv
// SPRAM write-address counter: circular wrap with sticky wrapped flag, or
// saturate at the last word with sticky full flag.
module spram_addr_ctr #(
  parameter int ADDR_W   = 14,
  parameter int CIRCULAR = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              at_max,
  output logic              wrapped,
  output logic              full
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic              full_q, full_d;

  assign at_max = (addr_q == '1);

  always_comb begin
    addr_d    = addr_q;
    wrapped_d = wrapped_q;
    full_d    = full_q;
    if (clear) begin
      addr_d    = '0;
      wrapped_d = 1'b0;
      full_d    = 1'b0;
    end else if (inc) begin
      if (!at_max) begin
        addr_d = addr_q + ADDR_W'(1);
      end else if (CIRCULAR != 0) begin
        addr_d    = '0;
        wrapped_d = 1'b1;
      end else begin
        // Last word written: hold the address and flag exhaustion.
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      wrapped_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wrapped_q <= wrapped_d;
      full_q    <= full_d;
    end
  end

  assign addr    = addr_q;
  assign wrapped = wrapped_q;
  assign full    = full_q;

endmodule

// File: rtl/sample_sequencer.sv
// Round-robin sensor sampler: request/ready per channel, settle for
// LOAD_CYCLES, then one SPRAM write at an internally managed address.
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 14,
  parameter int LOAD_CYCLES = 2,
  parameter int CIRCULAR    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  output logic                    sens_req,
  output logic [ch_w(NUM_CH)-1:0] sens_ch,
  input  logic                    sens_ready,
  input  logic [DATA_W-1:0]       sens_data,
  output logic                    spram_we,
  output logic [ADDR_W-1:0]       spram_addr,
  output logic [DATA_W-1:0]       spram_wdata,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    full,
  output logic                    wrapped,
  output seq_state_t              dbg_state
);

  localparam int              CH_W    = ch_w(NUM_CH);
  localparam int              LC_W    = ch_w(LOAD_CYCLES);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [LC_W-1:0] LC_INIT = LC_W'(LOAD_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stop_pend_q, stop_pend_d;

  logic              ctr_inc, ctr_clear;
  logic [ADDR_W-1:0] ctr_addr;
  logic              ctr_at_max, ctr_full, ctr_wrapped;

  spram_addr_ctr #(
    .ADDR_W  (ADDR_W),
    .CIRCULAR(CIRCULAR)
  ) u_addr_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (ctr_inc),
    .clear  (ctr_clear),
    .addr   (ctr_addr),
    .at_max (ctr_at_max),
    .wrapped(ctr_wrapped),
    .full   (ctr_full)
  );

  // Handshake: sens_req stays high in REQUEST until a cycle with sens_ready
  // high; that cycle transfers sens_data and the request is then committed
  // through SAVE, whatever stop does afterwards.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    lcnt_d      = lcnt_q;
    data_d      = data_q;
    stop_pend_d = stop_pend_q;
    ctr_inc     = 1'b0;
    ctr_clear   = 1'b0;

    if (state_q != IDLE && stop) stop_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        ch_d        = '0;
        if (clear) begin
          ctr_clear = 1'b1;
        end else if (start && !stop && !ctr_full) begin
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (sens_ready) begin
          data_d  = sens_data;
          lcnt_d  = LC_INIT;
          state_d = LOAD;
        end else if (stop || stop_pend_q) begin
          state_d     = IDLE;
          ch_d        = '0;
          stop_pend_d = 1'b0;
        end
      end
      LOAD: begin
        if (lcnt_q == '0) state_d = SAVE;
        else lcnt_d = lcnt_q - LC_W'(1);
      end
      SAVE: begin
        ctr_inc = 1'b1;
        ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
        // Saturating mode forces IDLE once the final word has been written.
        if (start && !stop && !stop_pend_q && !(CIRCULAR == 0 && ctr_at_max)) begin
          state_d = REQUEST;
        end else begin
          state_d     = IDLE;
          ch_d        = '0;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      lcnt_q      <= '0;
      data_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      lcnt_q      <= lcnt_d;
      data_q      <= data_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign sens_req    = (state_q == REQUEST);
  assign sens_ch     = ch_q;
  assign spram_we    = (state_q == SAVE);
  assign spram_addr  = ctr_addr;
  assign spram_wdata = data_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == SAVE) && (ch_q == LAST_CH);
  assign full        = ctr_full;
  assign wrapped     = ctr_wrapped;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer: a circular instance and a
// stop-when-full instance, both with an 8-word memory.
module tb_sample_sequencer;
  import sample_seq_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 3;
  localparam int DEPTH       = 8;
  localparam int LOAD_CYCLES = 2;
  localparam int EXP_W       = 53;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start[2], stop[2], clear[2], sens_ready[2];
  logic [DATA_W-1:0] sens_data[2];
  logic              sens_req[2], we[2], busy[2], fd[2], full[2], wrapped[2];
  logic [1:0]        sens_ch[2];
  logic [ADDR_W-1:0] addr[2];
  logic [DATA_W-1:0] wdata[2];
  seq_state_t        dbg[2];

  sample_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                     .LOAD_CYCLES(LOAD_CYCLES), .CIRCULAR(1)) u_circ (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .stop(stop[0]), .clear(clear[0]),
    .sens_req(sens_req[0]), .sens_ch(sens_ch[0]), .sens_ready(sens_ready[0]),
    .sens_data(sens_data[0]), .spram_we(we[0]), .spram_addr(addr[0]),
    .spram_wdata(wdata[0]), .busy(busy[0]), .frame_done(fd[0]), .full(full[0]),
    .wrapped(wrapped[0]), .dbg_state(dbg[0]));

  sample_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                     .LOAD_CYCLES(LOAD_CYCLES), .CIRCULAR(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .stop(stop[1]), .clear(clear[1]),
    .sens_req(sens_req[1]), .sens_ch(sens_ch[1]), .sens_ready(sens_ready[1]),
    .sens_data(sens_data[1]), .spram_we(we[1]), .spram_addr(addr[1]),
    .spram_wdata(wdata[1]), .busy(busy[1]), .frame_done(fd[1]), .full(full[1]),
    .wrapped(wrapped[1]), .dbg_state(dbg[1]));

  // scoreboard state; entry = {due[31:0], wrapped_before, frame_done, addr, data}
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[2][$];
  int m_ch[2], m_addr[2], m_writes[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every write strobe is matched against the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [EXP_W-1:0] e;
      if (we[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: inst %0d addr %0d data 0x%0h, expected no write", i, addr[i], wdata[i]);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("wr_addr[%0d]", i), 32'(addr[i]), 32'(e[18:16]));
          check($sformatf("wr_data[%0d]", i), 32'(wdata[i]), 32'(e[15:0]));
          check($sformatf("frame_done[%0d]", i), 32'(fd[i]), 32'(e[19]));
          check($sformatf("wrapped_before[%0d]", i), 32'(wrapped[i]), 32'(e[20]));
          check($sformatf("wr_latency[%0d]", i), cyc, e[52:21]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_req(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sens_req[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: inst %0d sens_req stayed 0, expected 1", i);
    end
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy[i]) break;
    end
    check($sformatf("busy_idle[%0d]", i), 32'(busy[i]), 0);
  endtask

  task automatic do_sample(input int i, input logic [DATA_W-1:0] d, input int stall);
    bit ok;
    wait_req(i, ok);
    if (!ok) return;
    check($sformatf("sens_ch[%0d]", i), 32'(sens_ch[i]), m_ch[i]);
    for (int k = 0; k < stall; k++) begin
      check("stall_req", 32'(sens_req[i]), 1);
      check("stall_ch", 32'(sens_ch[i]), m_ch[i]);
      check("stall_no_we", 32'(we[i]), 0);
      @(negedge clk);
    end
    sens_ready[i] = 1'b1;
    sens_data[i]  = d;
    exp_q[i].push_back({32'(cyc + LOAD_CYCLES + 1),
                        (i == 0 && m_writes[i] >= DEPTH),
                        (m_ch[i] == NUM_CH - 1),
                        3'(m_addr[i]), d});
    m_ch[i]     = (m_ch[i] + 1) % NUM_CH;
    m_addr[i]   = (m_addr[i] + 1) % DEPTH;
    m_writes[i] = m_writes[i] + 1;
    @(negedge clk);
    sens_ready[i] = 1'b0;
    sens_data[i]  = DATA_W'($urandom);
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 20 && exp_q[i].size() != 0; k++) @(negedge clk);
    check($sformatf("drain[%0d]", i), exp_q[i].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; stop[i] = 0; clear[i] = 0; sens_ready[i] = 0; sens_data[i] = '0;
      m_ch[i] = 0; m_addr[i] = 0; m_writes[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy[0]), 0);
    check("reset_req", 32'(sens_req[0]), 0);

    // reset asserted in the middle of a SAVE
    start[0] = 1'b1;
    wait_req(0, ok);
    sens_ready[0] = 1'b1;
    sens_data[0]  = 16'hBEEF;
    @(negedge clk);
    sens_ready[0] = 1'b0;
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_we", 32'(we[0]), 1);
    check("pre_reset_wdata", 32'(wdata[0]), 32'hBEEF);
    reset_n = 1'b0;
    #1;
    check("async_we_drop", 32'(we[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_req", 32'(sens_req[0]), 0);
    check("rst_ch", 32'(sens_ch[0]), 0);
    check("rst_addr", 32'(addr[0]), 0);
    check("rst_wdata", 32'(wdata[0]), 0);
    check("rst_flags", {29'd0, fd[0], full[0], wrapped[0]}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_start", 32'(busy[0]), 0);
    end

    // frame sequencing, then a 20-cycle stall on channel 2
    start[0] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) do_sample(0, DATA_W'(16'h1000 + c), 0);
    do_sample(0, DATA_W'($urandom), 0);
    do_sample(0, DATA_W'($urandom), 0);
    do_sample(0, DATA_W'($urandom), 20);
    do_sample(0, DATA_W'($urandom), 0);
    do_sample(0, DATA_W'($urandom), 0);

    // stop during LOAD of channel 1 while start stays high
    do_sample(0, DATA_W'($urandom), 0);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    wait_idle(0);
    start[0] = 1'b0;
    m_ch[0] = 0;
    check("stop_load_written", exp_q[0].size(), 0);
    check("wrapped_sticky", 32'(wrapped[0]), 1);
    repeat (3) begin
      @(negedge clk);
      check("stop_stays_idle", 32'(busy[0]), 0);
    end

    // start and stop together in IDLE
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("start_stop_idle", 32'(busy[0]), 0);
    end

    // resume at channel 0, then stop in REQUEST before sens_ready
    start[0] = 1'b1;
    do_sample(0, DATA_W'($urandom), 0);
    wait_req(0, ok);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0]  = 1'b0;
    start[0] = 1'b0;
    check("stop_req_idle", 32'(busy[0]), 0);
    check("stop_req_no_we", 32'(we[0]), 0);
    m_ch[0] = 0;
    repeat (3) @(negedge clk);

    // randomized run with random ready delays
    start[0] = 1'b1;
    for (int n = 0; n < 12; n++) do_sample(0, DATA_W'($urandom), $urandom_range(0, 3));
    start[0] = 1'b0;
    wait_idle(0);
    m_ch[0] = 0;
    drain(0);

    // stop-when-full instance
    start[1] = 1'b1;
    for (int n = 0; n < DEPTH; n++) do_sample(1, DATA_W'($urandom), $urandom_range(0, 2));
    wait_idle(1);
    m_ch[1] = 0;
    check("full_set", 32'(full[1]), 1);
    check("full_no_wrap", 32'(wrapped[1]), 0);
    repeat (5) begin
      @(negedge clk);
      check("full_ignores_start", 32'(busy[1]), 0);
    end
    clear[1] = 1'b1;
    @(negedge clk);
    clear[1] = 1'b0;
    check("clear_full", 32'(full[1]), 0);
    check("clear_beats_start", 32'(busy[1]), 0);
    m_addr[1] = 0;
    m_writes[1] = 0;
    do_sample(1, 16'hA5A5, 0);
    start[1] = 1'b0;
    wait_idle(1);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
